shiftadd_mult_ctrl: RTL and testbench
=====================================

Name: shiftadd_mult_ctrl

Overview:
Control FSM plus datapath registers for the shift-add multiplier. It sits directly beside Counter_ShiftAdd_Multiplier: it drives that counter's ld_count and its clear, and uses the counter's count output to decide when iteration ends. It accepts operands on a start/ready handshake, runs WIDTH add/shift iterations, and presents a 2*WIDTH-bit product with a one-cycle done pulse.

Parameters:
WIDTH, 4, operand width in bits; must be ≥2.
COUNT_DEPTH, log2(WIDTH) from log2_func.vh, localparam; the count port is COUNT_DEPTH+1 bits, matching the counter.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  asynchronous, active-low reset; 0 resets all state immediately.
start  input  1  request; sampled only when ready=1.
a  input  WIDTH  multiplicand; captured on accepted start.
b  input  WIDTH  multiplier; captured on accepted start.
count  input  COUNT_DEPTH+1  iteration count from the counter; equals the number of completed shifts.
ready  output  1  high only in IDLE.
ld_count  output  1  counter increment enable; high only in SHIFT.
cnt_clr  output  1  active-high counter clear; registered, high only in CLEAR.
product  output  2*WIDTH  result; held stable until the next accepted start.
done  output  1  one-cycle pulse when product becomes valid.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; acc, M, Q, product all 0; ready=1; done=0; ld_count=0; cnt_clr=0.
- Integration rule: counter rst = (~rst) | cnt_clr. cnt_clr comes straight from a flop, so it cannot glitch.
- Registers: M[WIDTH-1:0], Q[WIDTH-1:0], and acc[WIDTH:0]. acc has one extra bit to hold the add carry.
- States and transitions:
  - IDLE: ready=1. On start=1, capture M←a, Q←b, acc←0, and go to CLEAR.
  - CLEAR: cnt_clr=1 for exactly this cycle. Go to ADD; count reads 0 from ADD onward.
  - ADD: if Q[0]=1, acc←acc[WIDTH-1:0]+M (WIDTH+1-bit result); otherwise acc is unchanged. Go to SHIFT.
  - SHIFT:
    - {acc,Q} ← {1'b0, acc, Q[WIDTH-1:1]}, a logical right shift of the combined 2*WIDTH+1-bit register.
    - ld_count=1, so the counter increments at this edge.
    - If count==WIDTH-1, go to DONE; otherwise go to ADD.
  - DONE: product←{acc[WIDTH-1:0],Q} is registered at entry to DONE, and done=1 for this single cycle. Go to IDLE.
- Latency: start sampled at edge 0 → CLEAR in cycle 1 → 2*WIDTH ADD/SHIFT cycles → done high in cycle 2*WIDTH+2. For WIDTH=4, that is 10 cycles.
- Throughput: one op per 2*WIDTH+3 cycles. With start held high, the next op is accepted in the IDLE cycle after DONE.
- start while ready=0 is ignored. Changes on a/b during an op have no effect.
- Outputs ready, ld_count, cnt_clr and done are Moore outputs with no combinational path from inputs.
- Count sanity: if count > WIDTH-1 in SHIFT (counter desync), go to DONE anyway, so the FSM never hangs.
- Reset asserted mid-op aborts the op: the FSM returns to IDLE, product=0, and no done pulse is issued.
- Unsigned arithmetic only. The product MSB is acc[WIDTH-1] after the final shift, so the carry is retained: 15*15=225.

Decomposition:
- Shared package/header: state encodings (IDLE, CLEAR, ADD, SHIFT, DONE; 3-bit binary) and the log2 function, reused from log2_func.vh.
- Optional sub-module shiftadd_mult_dp holds acc/M/Q and the add/shift logic, controlled by load/add_en/shift_en. The FSM stays in shiftadd_mult_ctrl and the counter stays external.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release → ready=1, product=0, done=0, ld_count=0, cnt_clr=0.
- WIDTH=4, a=13, b=11, start pulse → cnt_clr high exactly 1 cycle; ld_count high 4 cycles; done in cycle 10; product=8'h8F (143).
- a=15, b=15 → product=8'hE1 (225), carry path exercised. a=0, b=9 → product=0 with the same 10-cycle latency.
- start held high with a=3, b=5 and then a=2, b=7 → products 15 then 14. Second ready rises the cycle after each done, with no overlap. Changes to a/b mid-op are ignored.
- rst=0 asserted in an ADD cycle of the op a=7, b=7 → immediate IDLE, product=0, no done. The next op a=2, b=3 gives product 6 with correct latency.
- Force count to 6 (desync) during SHIFT of the op a=5, b=5 → FSM reaches DONE and done pulses within 2 cycles; the FSM must not hang.

Source files
------------

// File: rtl/shiftadd_mult_ctrl_pkg.sv
// Shared definitions for the shift-add multiplier controller: FSM encoding and
// the log2 helper used to size the external iteration counter.
package shiftadd_mult_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StAdd   = 3'd2,
    StShift = 3'd3,
    StDone  = 3'd4
  } state_e;

  // Ceiling log2; matches the sizing used by the companion counter.
  function automatic int unsigned log2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/shiftadd_mult_ctrl_if.sv
// Operand/result handshake between a requester and the shift-add multiplier.
interface shiftadd_mult_ctrl_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 ready;
  logic [2*WIDTH-1:0]   product;
  logic                 done;

  modport master (
    output start, a, b,
    input  ready, product, done
  );

  modport slave (
    input  start, a, b,
    output ready, product, done
  );

endinterface

// File: rtl/shiftadd_mult_ctrl_dp.sv
// Datapath for the shift-add multiplier: multiplicand, multiplier/low product,
// accumulator with carry bit, and the registered product.
module shiftadd_mult_ctrl_dp #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 add_en,
  input  logic                 shift_en,
  input  logic                 prod_en,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product
);

  logic [WIDTH:0]       acc_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   product_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
    end else begin
      if (load) begin
        acc_q    <= '0;
        mcand_q  <= a;
        mplier_q <= b;
      end else if (add_en) begin
        if (mplier_q[0]) acc_q <= {1'b0, acc_q[WIDTH-1:0]} + {1'b0, mcand_q};
      end else if (shift_en) begin
        acc_q    <= {1'b0, acc_q[WIDTH:1]};
        mplier_q <= {acc_q[0], mplier_q[WIDTH-1:1]};
      end
      // Captures the value {acc, Q} will hold after this final shift.
      if (prod_en) product_q <= {acc_q, mplier_q[WIDTH-1:1]};
    end
  end

  assign product = product_q;

endmodule

// File: rtl/shiftadd_mult_ctrl.sv
// Control FSM for the shift-add multiplier; drives the external iteration
// counter (ld_count / cnt_clr) and sequences the datapath.
module shiftadd_mult_ctrl
  import shiftadd_mult_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned COUNT_DEPTH = log2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  shiftadd_mult_ctrl_if.slave    bus,
  input  logic [COUNT_DEPTH:0]   count,
  output logic                   ld_count,
  output logic                   cnt_clr
);

  localparam int unsigned LastIdx = WIDTH - 1;

  state_e state_q;
  logic   ready_q;
  logic   ld_count_q;
  logic   cnt_clr_q;
  logic   done_q;
  logic   last;
  logic   load;
  logic   add_en;
  logic   shift_en;
  logic   prod_en;

  // '>=' rather than '==' so a desynced counter still terminates the op.
  assign last     = 32'(count) >= LastIdx;
  assign load     = (state_q == StIdle) && bus.start;
  assign add_en   = (state_q == StAdd);
  assign shift_en = (state_q == StShift);
  assign prod_en  = shift_en && last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      ready_q    <= 1'b1;
      ld_count_q <= 1'b0;
      cnt_clr_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      ready_q    <= 1'b0;
      ld_count_q <= 1'b0;
      cnt_clr_q  <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q   <= StClear;
            cnt_clr_q <= 1'b1;
          end else begin
            ready_q <= 1'b1;
          end
        end
        StClear: state_q <= StAdd;
        StAdd: begin
          state_q    <= StShift;
          ld_count_q <= 1'b1;
        end
        StShift: begin
          if (last) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            state_q <= StAdd;
          end
        end
        StDone: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign ld_count  = ld_count_q;
  assign cnt_clr   = cnt_clr_q;

  shiftadd_mult_ctrl_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .add_en   (add_en),
    .shift_en (shift_en),
    .prod_en  (prod_en),
    .a        (bus.a),
    .b        (bus.b),
    .product  (bus.product)
  );

endmodule

// File: tb/tb_shiftadd_mult_ctrl.sv
// Self-checking bench for shiftadd_mult_ctrl with a behavioural iteration counter
// and a scoreboard of expected products, latencies and counter-control activity.
module tb_shiftadd_mult_ctrl;
  import shiftadd_mult_ctrl_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned CD = log2(W);

  typedef struct {
    logic [2*W-1:0] prod;
    int             iters;
    int             acc_cyc;
  } sb_t;

  logic          clk;
  logic          rst;
  logic [CD:0]   count;
  logic          ld_count;
  logic          cnt_clr;
  logic [CD:0]   cnt;
  logic          cnt_rst;
  logic          force_en;
  logic [CD:0]   force_val;

  int  n_checks;
  int  n_errors;
  int  cyc;
  int  sb_iters;
  int  clr_cnt;
  int  ld_cnt;
  bit  ready_next;
  sb_t sb_q[$];
  sb_t e;

  shiftadd_mult_ctrl_if #(.WIDTH(W)) bus ();

  shiftadd_mult_ctrl #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .count    (count),
    .ld_count (ld_count),
    .cnt_clr  (cnt_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model of the companion counter, with a desync override.
  assign cnt_rst = ~rst | cnt_clr;
  always @(posedge clk or posedge cnt_rst) begin
    if (cnt_rst) cnt <= '0;
    else if (ld_count) cnt <= cnt + 1'b1;
  end
  assign count = force_en ? force_val : cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference algorithm, used only for ops cut short by a counter desync.
  function automatic logic [2*W-1:0] model_partial(input logic [W-1:0] a, input logic [W-1:0] b,
                                                   input int iters);
    logic [W:0]     acc;
    logic [W-1:0]   q;
    logic [2*W:0]   comb;
    acc = '0;
    q   = b;
    for (int i = 0; i < iters; i++) begin
      if (q[0]) acc = {1'b0, acc[W-1:0]} + {1'b0, a};
      comb = {acc, q} >> 1;
      acc  = comb[2*W:W];
      q    = comb[W-1:0];
    end
    return {acc[W-1:0], q};
  endfunction

  function automatic logic [2*W-1:0] expected_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                   input int iters);
    logic [2*W-1:0] ea;
    logic [2*W-1:0] eb;
    ea = {{W{1'b0}}, a};
    eb = {{W{1'b0}}, b};
    if (iters == int'(W)) return ea * eb;
    return model_partial(a, b, iters);
  endfunction

  // Scoreboard: push on accepted start, pop and compare on done.
  always @(negedge clk) begin
    if (!rst) begin
      sb_q.delete();
      clr_cnt    = 0;
      ld_cnt     = 0;
      ready_next = 1'b0;
    end else begin
      if (ready_next) begin
        check_eq("ready_after_done", 64'(bus.ready), 64'd1);
        ready_next = 1'b0;
      end
      if (cnt_clr) clr_cnt++;
      if (ld_count) ld_cnt++;
      if (bus.ready && bus.start) begin
        sb_q.push_back('{prod: expected_prod(bus.a, bus.b, sb_iters), iters: sb_iters,
                         acc_cyc: cyc});
        clr_cnt = 0;
        ld_cnt  = 0;
      end
      if (bus.done) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("product", 64'(bus.product), 64'(e.prod));
          check_eq("latency", 64'(cyc - e.acc_cyc), 64'(2 * e.iters + 2));
          check_eq("cnt_clr_cycles", 64'(clr_cnt), 64'd1);
          check_eq("ld_count_cycles", 64'(ld_cnt), 64'(e.iters));
          check_eq("ready_during_done", 64'(bus.ready), 64'd0);
          ready_next = 1'b1;
        end
      end
    end
  end

  task automatic wait_accept();
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ready) break;
    end
    check_eq("accept_bound", 64'(i < 40), 64'd1);
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (sb_q.size() == 0) break;
    end
    check_eq("drain", 64'(sb_q.size()), 64'd0);
    @(posedge clk);
    #2;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    wait_accept();
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    wait_drain();
  endtask

  initial begin
    bit saw_done;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    force_en  = 1'b0;
    force_val = '0;
    sb_iters  = W;

    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_ready", 64'(bus.ready), 64'd1);
    check_eq("rst_product", 64'(bus.product), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_ld_count", 64'(ld_count), 64'd0);
    check_eq("rst_cnt_clr", 64'(cnt_clr), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #2;

    run_op(4'd13, 4'd11);
    run_op(4'd0, 4'd9);
    run_op(4'd15, 4'd15);
    repeat (3) @(posedge clk);
    #2;
    check_eq("product_hold", 64'(bus.product), 64'hE1);

    // Back-to-back with start held; operand changes mid-op must be ignored.
    bus.a     = 4'd3;
    bus.b     = 4'd5;
    bus.start = 1'b1;
    wait_accept();
    bus.a = 4'd9;
    bus.b = 4'd9;
    repeat (3) @(posedge clk);
    #2;
    bus.a = 4'd2;
    bus.b = 4'd7;
    wait_accept();
    bus.start = 1'b0;
    bus.a     = 4'd15;
    bus.b     = 4'd15;
    wait_drain();

    // Abort in an ADD cycle.
    bus.a     = 4'd7;
    bus.b     = 4'd7;
    bus.start = 1'b1;
    wait_accept();
    bus.start = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_eq("abort_ready", 64'(bus.ready), 64'd1);
    check_eq("abort_product", 64'(bus.product), 64'd0);
    check_eq("abort_done", 64'(bus.done), 64'd0);
    check_eq("abort_ld_count", 64'(ld_count), 64'd0);
    check_eq("abort_cnt_clr", 64'(cnt_clr), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    check_eq("no_done_after_abort", 64'(saw_done), 64'd0);
    @(posedge clk);
    #2;
    run_op(4'd2, 4'd3);

    // Counter desync in the first SHIFT: op must end after one iteration.
    sb_iters  = 1;
    bus.a     = 4'd5;
    bus.b     = 4'd5;
    bus.start = 1'b1;
    wait_accept();
    bus.start = 1'b0;
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    check_eq("desync_in_shift", 64'(ld_count), 64'd1);
    force_val = 3'd6;
    force_en  = 1'b1;
    wait_drain();
    force_en = 1'b0;
    sb_iters = W;
    run_op(4'd6, 4'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
